// File: rtl/i2c_pkg.sv
// Shared types and constants for the I2C master PHY.
// The state encoding, bit-phase names and SCL quarter-period divider live here.
package i2c_pkg;

    localparam logic CMD_WRITE = 1'b1;
    localparam logic CMD_READ  = 1'b0;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_TX_BYTE,
        ST_RSTART,
        ST_RX_BYTE,
        ST_STOP,
        ST_DONE,
        ST_RELEASE
    } state_t;

    // Four qtick phases per bit.
    localparam logic [1:0] PH_SETUP   = 2'd0;
    localparam logic [1:0] PH_SCL_REL = 2'd1;
    localparam logic [1:0] PH_SAMPLE  = 2'd2;
    localparam logic [1:0] PH_SCL_LOW = 2'd3;

    localparam logic [3:0] ACK_BIT = 4'd8;

    function automatic int qdiv(input int clk_hz, input int i2c_hz);
        int q;
        q = clk_hz / (4 * i2c_hz);
        return (q < 1) ? 1 : q;
    endfunction

endpackage

// File: rtl/i2c_qtick_gen.sv
// Quarter-SCL-period tick generator: counts 0..QDIV-1 while run is high and
// pulses qtick on wrap; held at 0 whenever run is low.
module i2c_qtick_gen #(
    parameter int QDIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic run,
    output logic qtick
);

    localparam int CW = (QDIV > 1) ? $clog2(QDIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(QDIV - 1);

    logic [CW-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst_n || !run) begin
            cnt <= '0;
        end else if (cnt == LAST) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + CW'(1);
        end
    end

    assign qtick = run && (cnt == LAST);

endmodule

// File: rtl/i2c_master_phy.sv
// Bit-level I2C master serving one register write/read per request.
// Define I2C_WR16_EN to append data_wr_L as a fifth byte on writes.
module i2c_master_phy
    import i2c_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 50000000,
    parameter int I2C_FREQ_HZ = 400000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i2c_rqt,
    input  logic       cmd,
    input  logic [6:0] addr_dev,
    input  logic [7:0] addr_reg_H,
    input  logic [7:0] addr_reg_L,
    input  logic [7:0] data_wr_H,
    input  logic [7:0] data_wr_L,
    output logic       i2c_done,
    output logic       data_rdy,
    output logic [7:0] data_rd,
    output logic       ack_err,
    output logic       busy,
    output logic       scl_oe,
    output logic       sda_oe,
    input  logic       sda_i
);

    localparam int QDIV = qdiv(CLK_FREQ_HZ, I2C_FREQ_HZ);

`ifdef I2C_WR16_EN
    localparam logic [2:0] LAST_WR_IDX = 3'd4;
`else
    localparam logic [2:0] LAST_WR_IDX = 3'd3;
`endif

    state_t     state, state_next;
    logic       run, qtick, accept, bit_end, byte_end;
    logic [1:0] phase;
    logic [3:0] bit_cnt;
    logic [2:0] byte_idx;
    logic [7:0] tx_cur, rx_shift;
    logic       scl_drive, sda_drive;

    logic       is_write;
    logic [6:0] dev;
    logic [7:0] reg_h, reg_l, wr_h, wr_l;

    assign run      = state inside {ST_START, ST_TX_BYTE, ST_RSTART, ST_RX_BYTE, ST_STOP};
    assign accept   = (state == ST_IDLE) && i2c_rqt;
    assign bit_end  = qtick && (phase == PH_SCL_LOW);
    assign byte_end = bit_end && (bit_cnt == ACK_BIT);

    i2c_qtick_gen #(.QDIV(QDIV)) u_qtick (
        .clk   (clk),
        .rst_n (rst_n),
        .run   (run),
        .qtick (qtick)
    );

    // Byte index 3 is the last write byte or the read address, depending on cmd.
    always_comb begin
        tx_cur = {dev, 1'b0};
        case (byte_idx)
            3'd1:    tx_cur = reg_h;
            3'd2:    tx_cur = reg_l;
            3'd3:    tx_cur = is_write ? wr_h : {dev, 1'b1};
            3'd4:    tx_cur = wr_l;
            default: tx_cur = {dev, 1'b0};
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        // NOTE: every output gets a default before the case so no path infers a latch.
        state_next = state;
        scl_drive  = 1'b0;
        sda_drive  = 1'b0;
        unique case (state)
            ST_IDLE: begin
                if (i2c_rqt) state_next = ST_START;
            end
            ST_START: begin
                sda_drive = 1'b1;
                scl_drive = (phase == PH_SCL_REL);
                if (qtick && phase == PH_SCL_REL) state_next = ST_TX_BYTE;
            end
            ST_TX_BYTE: begin
                scl_drive = (phase == PH_SETUP) || (phase == PH_SCL_LOW);
                sda_drive = (bit_cnt != ACK_BIT) && !tx_cur[~bit_cnt[2:0]];
                if (byte_end) begin
                    if (ack_err)                                   state_next = ST_STOP;
                    else if (is_write && byte_idx == LAST_WR_IDX)  state_next = ST_STOP;
                    else if (!is_write && byte_idx == 3'd2)        state_next = ST_RSTART;
                    else if (!is_write && byte_idx == 3'd3)        state_next = ST_RX_BYTE;
                end
            end
            ST_RSTART: begin
                sda_drive = (phase == PH_SAMPLE) || (phase == PH_SCL_LOW);
                scl_drive = (phase == PH_SETUP) || (phase == PH_SCL_LOW);
                if (qtick && phase == PH_SCL_LOW) state_next = ST_TX_BYTE;
            end
            ST_RX_BYTE: begin
                scl_drive = (phase == PH_SETUP) || (phase == PH_SCL_LOW);
                if (byte_end) state_next = ST_STOP;
            end
            ST_STOP: begin
                sda_drive = (phase != PH_SAMPLE);
                scl_drive = (phase == PH_SETUP);
                if (qtick && phase == PH_SAMPLE) state_next = ST_DONE;
            end
            ST_DONE: begin
                state_next = ST_RELEASE;
            end
            ST_RELEASE: begin
                if (!i2c_rqt) state_next = ST_IDLE;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            phase    <= '0;
            bit_cnt  <= '0;
            byte_idx <= '0;
            rx_shift <= '0;
            ack_err  <= 1'b0;
            data_rd  <= '0;
            // NOTE: the request latches are reset too so tx_cur never carries X after reset.
            is_write <= CMD_READ;
            dev      <= '0;
            reg_h    <= '0;
            reg_l    <= '0;
            wr_h     <= '0;
            wr_l     <= '0;
        end else begin
            scl_oe <= scl_drive;
            sda_oe <= sda_drive;
            if (accept) begin
                is_write <= (cmd == CMD_WRITE);
                dev      <= addr_dev;
                reg_h    <= addr_reg_H;
                reg_l    <= addr_reg_L;
                wr_h     <= data_wr_H;
                wr_l     <= data_wr_L;
                ack_err  <= 1'b0;
                phase    <= '0;
                bit_cnt  <= '0;
                byte_idx <= '0;
            end else if (qtick) begin
                if (state_next != state) begin
                    phase   <= '0;
                    bit_cnt <= '0;
                end else begin
                    phase <= phase + 2'd1;
                    if (phase == PH_SCL_LOW) begin
                        bit_cnt <= (bit_cnt == ACK_BIT) ? 4'd0 : bit_cnt + 4'd1;
                    end
                end
                if (phase == PH_SAMPLE) begin
                    if (state == ST_TX_BYTE && bit_cnt == ACK_BIT && sda_i) ack_err <= 1'b1;
                    if (state == ST_RX_BYTE && bit_cnt != ACK_BIT) rx_shift <= {rx_shift[6:0], sda_i};
                end
                if (state == ST_TX_BYTE && byte_end) byte_idx <= byte_idx + 3'd1;
                if (state == ST_STOP && state_next == ST_DONE && !is_write && !ack_err) begin
                    data_rd <= rx_shift;
                end
            end
        end
    end

    assign i2c_done = (state == ST_DONE);
    assign data_rdy = (state == ST_DONE) && !is_write && !ack_err;
    assign busy     = run;

endmodule

// File: tb/tb_i2c_master_phy.sv
// Self-checking bench for i2c_master_phy: behavioural I2C slave/bus monitor plus
// a transaction-level reference model of the expected bus transcript.
module tb_i2c_master_phy;

    localparam int CLK_HZ = 10000000;
    localparam int I2C_HZ = 250000;
    localparam int QD     = 10;
    localparam int TOK_S  = 1000;
    localparam int TOK_P  = 1001;
    localparam int NONE   = 99;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       i2c_rqt = 1'b0;
    logic       cmd = 1'b0;
    logic [6:0] addr_dev = '0;
    logic [7:0] addr_reg_H = '0, addr_reg_L = '0, data_wr_H = '0, data_wr_L = '0;
    logic       i2c_done, data_rdy, ack_err, busy, scl_oe, sda_oe, sda_i;
    logic [7:0] data_rd;

    int n_cmp = 0;
    int n_bad = 0;
    int mon_q[$];
    int exp_q[$];

    logic       slave_pull = 1'b0;
    int         slave_nack_at = NONE;
    logic [7:0] slave_rd_data = '0;

    i2c_master_phy #(.CLK_FREQ_HZ(CLK_HZ), .I2C_FREQ_HZ(I2C_HZ)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .i2c_rqt    (i2c_rqt),
        .cmd        (cmd),
        .addr_dev   (addr_dev),
        .addr_reg_H (addr_reg_H),
        .addr_reg_L (addr_reg_L),
        .data_wr_H  (data_wr_H),
        .data_wr_L  (data_wr_L),
        .i2c_done   (i2c_done),
        .data_rdy   (data_rdy),
        .data_rd    (data_rd),
        .ack_err    (ack_err),
        .busy       (busy),
        .scl_oe     (scl_oe),
        .sda_oe     (sda_oe),
        .sda_i      (sda_i)
    );

    always #5 clk = ~clk;

    assign sda_i = ~(sda_oe | slave_pull);

    // Behavioural slave: records START/STOP and every byte with its ACK bit.
    logic       prev_scl = 1'b1, prev_sda = 1'b1, scl_l, sda_l, s_ack, s_first, s_rd;
    int         s_bits, s_byte;
    logic [7:0] s_sh;

    always @(negedge clk) begin
        scl_l = ~scl_oe;
        sda_l = ~(sda_oe | slave_pull);
        if (!rst_n) begin
            slave_pull = 1'b0;
            s_bits = 0; s_byte = 0; s_sh = '0; s_ack = 1'b1; s_first = 1'b0; s_rd = 1'b0;
        end else if (prev_scl && scl_l && prev_sda && !sda_l) begin
            mon_q.push_back(TOK_S);
            s_bits = 0; s_sh = '0; s_first = 1'b1; slave_pull = 1'b0;
        end else if (prev_scl && scl_l && !prev_sda && sda_l) begin
            mon_q.push_back(TOK_P);
            s_bits = 0; s_byte = 0; s_rd = 1'b0; slave_pull = 1'b0;
        end else if (!prev_scl && scl_l) begin
            if (s_bits < 8) begin
                s_sh = {s_sh[6:0], sda_l};
            end else begin
                s_ack = sda_l;
                mon_q.push_back(int'({s_ack, s_sh}));
            end
            s_bits++;
        end else if (prev_scl && !scl_l) begin
            if (s_bits == 9) begin
                slave_pull = 1'b0;
                if (s_rd) begin
                    s_rd = 1'b0;
                end else if (s_first && s_sh[0] && !s_ack) begin
                    s_rd = 1'b1;
                    slave_pull = ~slave_rd_data[7];
                end
                s_first = 1'b0; s_byte++; s_bits = 0;
            end else if (s_bits == 8) begin
                slave_pull = s_rd ? 1'b0 : (s_byte != slave_nack_at);
            end else if (s_rd && s_bits >= 1) begin
                slave_pull = ~slave_rd_data[7 - s_bits];
            end
        end
        prev_scl = scl_l;
        prev_sda = sda_l;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Reference model: transcript, busy length, ack_err and data_rdy from the transaction rules.
    task automatic build_exp(input logic c, input logic [6:0] dev, input logic [7:0] rh, rl, dh, dl, rdv,
                             input int nack_at, output int cyc, output bit err, output bit rdy);
        int seq[$];
        int qt;
        int idx;
        qt = 2; idx = 0; err = 1'b0;
        exp_q.delete();
        exp_q.push_back(TOK_S);
        seq.push_back(int'({dev, 1'b0}));
        seq.push_back(int'(rh));
        seq.push_back(int'(rl));
        if (c) begin
            seq.push_back(int'(dh));
`ifdef I2C_WR16_EN
            seq.push_back(int'(dl));
`endif
        end else begin
            seq.push_back(-1);
            seq.push_back(int'({dev, 1'b1}));
        end
        foreach (seq[k]) begin
            if (err) break;
            if (seq[k] < 0) begin
                exp_q.push_back(TOK_S);
                qt += 4;
            end else begin
                err = (idx == nack_at);
                exp_q.push_back(seq[k] | (err ? 256 : 0));
                qt += 36;
                idx++;
            end
        end
        rdy = !c && !err;
        if (rdy) begin
            exp_q.push_back(256 | int'(rdv));
            qt += 36;
        end
        exp_q.push_back(TOK_P);
        qt += 3;
        cyc = qt * QD;
    endtask

    task automatic run_txn(input logic c, input logic [6:0] dev, input logic [7:0] rh, rl, dh, dl, rdv,
                           input int nack_at, input bit pre_drop, input bit keep_rqt, input string name);
        int  exp_cyc, busy_cyc, rdy_cnt, i_acc, i_sda, n;
        bit  exp_err, exp_rdy, got;
        logic rdy_at_done, busy_at_done;
        busy_cyc = 0; rdy_cnt = 0; i_acc = -1; i_sda = -1; got = 1'b0;
        rdy_at_done = 1'b0; busy_at_done = 1'b1;
        build_exp(c, dev, rh, rl, dh, dl, rdv, nack_at, exp_cyc, exp_err, exp_rdy);
        slave_nack_at = nack_at;
        slave_rd_data = rdv;
        if (pre_drop) begin
            @(negedge clk);
            i2c_rqt = 1'b0;
        end
        // NOTE: inputs are driven with blocking assignments on the falling edge, clear of the sampling edge.
        @(negedge clk);
        mon_q.delete();
        cmd = c; addr_dev = dev; addr_reg_H = rh; addr_reg_L = rl; data_wr_H = dh; data_wr_L = dl;
        i2c_rqt = 1'b1;
        for (int i = 0; i < 8000 && !got; i++) begin
            @(posedge clk); #1;
            if (busy) begin
                busy_cyc++;
                if (i_acc < 0) i_acc = i;
            end
            if (sda_oe && i_sda < 0) i_sda = i;
            if (data_rdy) rdy_cnt++;
            if (i2c_done) begin
                got = 1'b1;
                rdy_at_done = data_rdy;
                busy_at_done = busy;
            end
        end
        check({name, ".done_seen"}, 32'(got), 32'd1);
        check({name, ".accept_edge"}, 32'(i_acc), 32'd0);
        check({name, ".start_lag"}, 32'(i_sda), 32'(i_acc + 1));
        check({name, ".busy_cycles"}, 32'(busy_cyc), 32'(exp_cyc));
        check({name, ".busy_at_done"}, 32'(busy_at_done), 32'd0);
        check({name, ".rdy_at_done"}, 32'(rdy_at_done), 32'(exp_rdy));
        check({name, ".rdy_count"}, 32'(rdy_cnt), 32'(exp_rdy));
        check({name, ".ack_err"}, 32'(ack_err), 32'(exp_err));
        if (exp_rdy) check({name, ".data_rd"}, 32'(data_rd), 32'(rdv));
        @(posedge clk); #1;
        check({name, ".done_single"}, 32'(i2c_done), 32'd0);
        check({name, ".ack_err_sticky"}, 32'(ack_err), 32'(exp_err));
        if (!keep_rqt) begin
            @(negedge clk);
            i2c_rqt = 1'b0;
        end
        check({name, ".tok_count"}, 32'(mon_q.size()), 32'(exp_q.size()));
        n = (mon_q.size() < exp_q.size()) ? mon_q.size() : exp_q.size();
        for (int k = 0; k < n; k++) begin
            check($sformatf("%s.tok%0d", name, k), 32'(mon_q[k]), 32'(exp_q[k]));
        end
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: observed no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic       c;
        logic [6:0] d;
        logic [7:0] rh, rl, dh, dl, rv;
        int         na;

        repeat (3) @(posedge clk);
        #1;
        check("rst.scl_oe", 32'(scl_oe), 32'd0);
        check("rst.sda_oe", 32'(sda_oe), 32'd0);
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(i2c_done), 32'd0);
        check("rst.rdy", 32'(data_rdy), 32'd0);
        check("rst.data_rd", 32'(data_rd), 32'd0);
        check("rst.ack_err", 32'(ack_err), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        repeat (2) @(posedge clk);

        run_txn(1'b1, 7'h36, 8'h30, 8'h00, 8'h0F, 8'($urandom()), 8'h00, NONE, 1'b0, 1'b0, "write");
        run_txn(1'b0, 7'h36, 8'h30, 8'h0A, 8'($urandom()), 8'($urandom()), 8'h56, NONE, 1'b0, 1'b0, "read");
        run_txn(1'b1, 7'h36, 8'h30, 8'h00, 8'h0F, 8'h00, 8'h00, 0, 1'b0, 1'b0, "nack_addr");
        run_txn(1'b0, 7'h36, 8'h30, 8'h0A, 8'h00, 8'h00, 8'h5A, 0, 1'b0, 1'b0, "nack_read");

        run_txn(1'b1, 7'h36, 8'h30, 8'h10, 8'hA5, 8'h00, 8'h00, NONE, 1'b0, 1'b1, "hs_first");
        mon_q.delete();
        repeat (60) @(posedge clk);
        #1;
        check("hs.no_restart_tokens", 32'(mon_q.size()), 32'd0);
        check("hs.busy_held_low", 32'(busy), 32'd0);
        check("hs.sda_released", 32'(sda_oe), 32'd0);
        check("hs.scl_released", 32'(scl_oe), 32'd0);
        run_txn(1'b1, 7'h36, 8'h30, 8'h11, 8'h5A, 8'h00, 8'h00, NONE, 1'b1, 1'b0, "hs_second");

        @(negedge clk);
        slave_nack_at = NONE;
        cmd = 1'b1; addr_dev = 7'h36; addr_reg_H = 8'h30; addr_reg_L = 8'h01; data_wr_H = 8'hC3;
        i2c_rqt = 1'b1;
        repeat (600) @(posedge clk);
        #1;
        check("rst_mid.busy_before", 32'(busy), 32'd1);
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); #1;
        check("rst_mid.scl_oe", 32'(scl_oe), 32'd0);
        check("rst_mid.sda_oe", 32'(sda_oe), 32'd0);
        check("rst_mid.busy", 32'(busy), 32'd0);
        check("rst_mid.done", 32'(i2c_done), 32'd0);
        check("rst_mid.rdy", 32'(data_rdy), 32'd0);
        check("rst_mid.data_rd", 32'(data_rd), 32'd0);
        check("rst_mid.ack_err", 32'(ack_err), 32'd0);
        @(negedge clk);
        i2c_rqt = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(posedge clk);
        run_txn(1'b1, 7'h36, 8'h30, 8'h01, 8'hC3, 8'h00, 8'h00, NONE, 1'b0, 1'b0, "after_rst");

        run_txn(1'b1, 7'h36, 8'h30, 8'h20, 8'h12, 8'h34, 8'h00, NONE, 1'b0, 1'b0, "wr16");

        for (int t = 0; t < 6; t++) begin
            c  = 1'($urandom_range(0, 1));
            d  = 7'($urandom());
            rh = 8'($urandom());
            rl = 8'($urandom());
            dh = 8'($urandom());
            dl = 8'($urandom());
            rv = 8'($urandom());
            na = $urandom_range(0, 7);
            run_txn(c, d, rh, rl, dh, dl, rv, na, 1'b0, 1'b0, $sformatf("rand%0d", t));
        end

        repeat (5) @(posedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
